// File: rtl/fifo_serializer_if.sv
// fifo_serializer_if: groups the upstream FIFO side and the downstream beat
// stream of fifo_serializer. Parameters must match the serializer instance.
//
// Handshakes:
//   upstream   - pnding_i says the FIFO head word on data_i is valid; pop_o is
//                a single-cycle request that consumes that head word on the
//                same rising edge.
//   downstream - a beat on data_o transfers on every rising edge where
//                valid_o=1 and ready_i=1; while valid_o=1 and ready_i=0 the
//                beat and parity_o stay stable until accepted.
interface fifo_serializer_if #(
  parameter int WIDTH = 32,
  parameter int OUT_W = 8
) ();
  logic             pnding_i;
  logic [WIDTH-1:0] data_i;
  logic             pop_o;
  logic             valid_o;
  logic             ready_i;
  logic [OUT_W-1:0] data_o;
  logic             parity_o;
  logic             busy_o;
  logic [15:0]      words_o;

  // Serializer side.
  modport master (
    input  pnding_i, data_i, ready_i,
    output pop_o, valid_o, data_o, parity_o, busy_o, words_o
  );

  // Environment side: the upstream FIFO plus the downstream sink.
  modport slave (
    output pnding_i, data_i, ready_i,
    input  pop_o, valid_o, data_o, parity_o, busy_o, words_o
  );
endinterface

// File: rtl/fifo_serializer.sv
// fifo_serializer: pops WIDTH-bit words from an upstream FIFO and sends each
// one LSB-first as WIDTH/OUT_W beats of OUT_W bits. A new word is popped on
// the last accepted beat of the previous one, so a full FIFO streams with no
// bubbles. words_o counts fully transmitted words (wraps at 2^16).
// Optional macro SERIALIZER_PARITY_EN: drive parity_o with the even parity of
// data_o; otherwise parity_o is tied to 0.
// dbg_state_o exposes the FSM state (0 = IDLE, 1 = SEND).
module fifo_serializer #(
  parameter int WIDTH = 32,
  parameter int OUT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  fifo_serializer_if.master    bus,
  output logic                 dbg_state_o
);
  localparam int BEATS = WIDTH / OUT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   beat_q, beat_d;
  logic [15:0]        words_q, words_d;
  logic               pop;
  logic               last_beat;

  assign last_beat = (beat_q == CNT_W'(BEATS - 1));

  // State register and datapath; reset clears everything at once.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      beat_q  <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      beat_q  <= beat_d;
      words_q <= words_d;
    end
  end

  // Next-state logic: load on pop, shift on non-final beats, chain words.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    beat_d  = beat_q;
    words_d = words_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.pnding_i) begin
          pop     = 1'b1;
          shift_d = bus.data_i;
          beat_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.ready_i) begin
          if (last_beat) begin
            words_d = words_q + 16'd1;
            if (bus.pnding_i) begin
              // Chain the next word in the same cycle to avoid an idle bubble.
              pop     = 1'b1;
              shift_d = bus.data_i;
              beat_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shift_d = shift_q >> OUT_W;
            beat_d  = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The last beat is never shifted out, so data_o keeps it while idle.
  // pop is gated by reset so nothing is consumed while reset is held.
  assign bus.pop_o    = pop & rst_i;
  assign bus.valid_o  = (state_q == SEND);
  assign bus.busy_o   = (state_q == SEND);
  assign bus.data_o   = shift_q[OUT_W-1:0];
  assign bus.words_o  = words_q;
  assign dbg_state_o  = state_q;

`ifdef SERIALIZER_PARITY_EN
  assign bus.parity_o = ^bus.data_o;
`else
  assign bus.parity_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_serializer.sv
// tb_fifo_serializer: directed bench for fifo_serializer (32-bit words, 8-bit
// beats) plus a second 8/8 instance that streams one word per cycle to reach
// the 16-bit words_o wrap. A beat-queue model predicts every output on every
// falling edge; directed steps add literal expectations.
module tb_fifo_serializer;
  logic clk = 1'b0;
  logic rst;
  logic rst2;
  logic dbg_state;
  logic wdbg_state;

  always #5 clk = ~clk;

  fifo_serializer_if #(.WIDTH(32), .OUT_W(8)) bus ();
  fifo_serializer_if #(.WIDTH(8),  .OUT_W(8)) wbus ();

  fifo_serializer #(.WIDTH(32), .OUT_W(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  fifo_serializer #(.WIDTH(8), .OUT_W(8)) dut_wrap (
    .clk_i       (clk),
    .rst_i       (rst2),
    .bus         (wbus),
    .dbg_state_o (wdbg_state)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit wrap_done = 1'b0;

  // Model state: beats still owed for the current/next word, last beat shown.
  logic [7:0]  beat_m[$];
  logic [7:0]  last_m;
  logic [15:0] words_m;

  // Observation logs and literal expectations for directed steps.
  logic [7:0]  acc_q[$];
  int          acc_cyc_q[$];
  int          pop_cyc_q[$];
  logic [7:0]  exp_q[$];

  logic        e_valid, e_pop, e_par;
  logic [7:0]  e_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic check_beats(input string name);
    chk({name, "_count"}, acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
      chk({name, "_beat"}, acc_q[i], exp_q[i]);
  endtask

  task automatic clear_logs();
    acc_q.delete();
    acc_cyc_q.delete();
    pop_cyc_q.delete();
    exp_q.delete();
  endtask

  // Compare process: predict outputs from the beat queue, then advance it.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      beat_m.delete();
      last_m  = 8'h00;
      words_m = 16'h0000;
      chk("rst_valid", bus.valid_o, 1'b0);
      chk("rst_busy", bus.busy_o, 1'b0);
      chk("rst_pop", bus.pop_o, 1'b0);
      chk("rst_data", bus.data_o, 8'h00);
      chk("rst_words", bus.words_o, 16'h0000);
    end else begin
      e_valid = (beat_m.size() > 0);
      e_data  = e_valid ? beat_m[0] : last_m;
      e_pop   = bus.pnding_i && (beat_m.size() == 0 ||
                                 (beat_m.size() == 1 && bus.ready_i));
`ifdef SERIALIZER_PARITY_EN
      e_par   = ^e_data;
`else
      e_par   = 1'b0;
`endif
      chk("m_valid", bus.valid_o, e_valid);
      chk("m_busy", bus.busy_o, e_valid);
      chk("m_state", dbg_state, e_valid);
      chk("m_data", bus.data_o, e_data);
      chk("m_pop", bus.pop_o, e_pop);
      chk("m_parity", bus.parity_o, e_par);
      chk("m_words", bus.words_o, words_m);
      if (bus.valid_o && bus.ready_i) begin
        acc_q.push_back(bus.data_o);
        acc_cyc_q.push_back(cyc);
      end
      if (bus.pop_o) pop_cyc_q.push_back(cyc);
      if (e_valid) begin
        last_m = beat_m[0];
        if (bus.ready_i) begin
          void'(beat_m.pop_front());
          if (beat_m.size() == 0) words_m = words_m + 16'd1;
        end
      end
      if (e_pop)
        for (int i = 0; i < 4; i++) beat_m.push_back(bus.data_i[i*8 +: 8]);
    end
  end

  // Wrap instance: one-beat words streamed back to back until words_o wraps.
  initial begin : wrap_proc
    int n;
    n = 0;
    rst2 = 1'b0;
    wbus.pnding_i = 1'b1;
    wbus.ready_i  = 1'b1;
    wbus.data_i   = 8'h00;
    step();
    rst2 = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      chk("wrap_words", wbus.words_o, n[15:0]);
      if (n == 65535) chk("wrap_ffff", wbus.words_o, 16'hFFFF);
      if (n == 65536) begin
        chk("wrap_zero", wbus.words_o, 16'h0000);
        break;
      end
      if (wbus.valid_o && wbus.ready_i) n++;
      wbus.data_i = i[7:0];
    end
    wbus.pnding_i = 1'b0;
    wrap_done = 1'b1;
  end

  // Directed stimulus.
  initial begin
    rst = 1'b0;
    bus.pnding_i = 1'b1;
    bus.data_i   = 32'hFFFF_FFFF;
    bus.ready_i  = 1'b1;
    #3;
    chk("reset_valid", bus.valid_o, 1'b0);
    chk("reset_busy", bus.busy_o, 1'b0);
    chk("reset_pop_gated", bus.pop_o, 1'b0);
    chk("reset_data", bus.data_o, 8'h00);
    chk("reset_words", bus.words_o, 16'h0000);
    step();
    step();
    rst = 1'b1;
    bus.pnding_i = 1'b0;
    bus.data_i   = 32'h0;
    step();

    // Single word.
    clear_logs();
    bus.pnding_i = 1'b1;
    bus.data_i   = 32'hA1B2C3D4;
    step();
    bus.pnding_i = 1'b0;
    bus.data_i   = 32'h0;
    at_neg();
    chk("t1_first_valid", bus.valid_o, 1'b1);
    chk("t1_first_beat", bus.data_o, 8'hD4);
    repeat (4) step();
    at_neg();
    chk("t1_idle_valid", bus.valid_o, 1'b0);
    chk("t1_idle_hold", bus.data_o, 8'hA1);
    chk("t1_words", bus.words_o, 16'd1);
    chk("t1_pops", pop_cyc_q.size(), 1);
    exp_q = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    check_beats("t1");

    // Backpressure during beat 1.
    clear_logs();
    bus.pnding_i = 1'b1;
    bus.data_i   = 32'h11223344;
    step();
    bus.pnding_i = 1'b0;
    step();
    bus.ready_i = 1'b0;
    repeat (3) begin
      at_neg();
      chk("t2_hold_data", bus.data_o, 8'h33);
      chk("t2_hold_valid", bus.valid_o, 1'b1);
      step();
    end
    bus.ready_i = 1'b1;
    repeat (3) step();
    at_neg();
    chk("t2_idle_valid", bus.valid_o, 1'b0);
    chk("t2_words", bus.words_o, 16'd2);
    exp_q = '{8'h44, 8'h33, 8'h22, 8'h11};
    check_beats("t2");

    // Back-to-back words; words_o goes from 2 to 4.
    clear_logs();
    bus.pnding_i = 1'b1;
    bus.data_i   = 32'h01020304;
    step();
    bus.data_i   = 32'h05060708;
    repeat (4) step();
    bus.pnding_i = 1'b0;
    repeat (4) step();
    at_neg();
    chk("t3_idle_valid", bus.valid_o, 1'b0);
    chk("t3_words", bus.words_o, 16'd4);
    chk("t3_pops", pop_cyc_q.size(), 2);
    if (pop_cyc_q.size() == 2)
      chk("t3_pop_gap", pop_cyc_q[1] - pop_cyc_q[0], 4);
    if (acc_cyc_q.size() == 8)
      chk("t3_contiguous", acc_cyc_q[7] - acc_cyc_q[0], 7);
    exp_q = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05};
    check_beats("t3");

    // Reset after two beats, then a fresh word starting at beat 0.
    clear_logs();
    bus.pnding_i = 1'b1;
    bus.data_i   = 32'hDEADBEEF;
    step();
    bus.pnding_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("t4_rst_valid", bus.valid_o, 1'b0);
    chk("t4_rst_busy", bus.busy_o, 1'b0);
    chk("t4_rst_data", bus.data_o, 8'h00);
    chk("t4_rst_words", bus.words_o, 16'h0000);
    step();
    rst = 1'b1;
    bus.pnding_i = 1'b1;
    bus.data_i   = 32'h12340307;
    step();
    bus.pnding_i = 1'b0;
    at_neg();
    chk("t4_beat0", bus.data_o, 8'h07);
`ifdef SERIALIZER_PARITY_EN
    chk("t4_parity_07", bus.parity_o, 1'b1);
`else
    chk("t4_parity_07", bus.parity_o, 1'b0);
`endif
    step();
    at_neg();
    chk("t4_beat1", bus.data_o, 8'h03);
    chk("t4_parity_03", bus.parity_o, 1'b0);
    repeat (3) step();
    at_neg();
    chk("t4_idle_valid", bus.valid_o, 1'b0);
    chk("t4_words", bus.words_o, 16'd1);
    chk("t4_pops", pop_cyc_q.size(), 2);
    exp_q = '{8'hEF, 8'hBE, 8'h07, 8'h03, 8'h34, 8'h12};
    check_beats("t4");

    for (int i = 0; i < 70000 && !wrap_done; i++) @(posedge clk);
    chk("wrap_done", wrap_done, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
